// File: rtl/lcl_mmio_arbiter_if.sv
// Requester and downstream signal bundle for the local MMIO arbiter.
// master: arbiter view (drives downstream bus and requester responses).
// slave:  environment view (drives requests and downstream responses).
interface lcl_mmio_arbiter_if;
    logic        req0_wr;
    logic        req0_rd;
    logic [31:0] req0_addr;
    logic [31:0] req0_din;
    logic        req0_ack;
    logic        req0_dv;
    logic        req0_rsp;
    logic [31:0] req0_dout;

    logic        req1_wr;
    logic        req1_rd;
    logic [31:0] req1_addr;
    logic [31:0] req1_din;
    logic        req1_ack;
    logic        req1_dv;
    logic        req1_rsp;
    logic [31:0] req1_dout;

    logic        lcl_mmio_wr;
    logic        lcl_mmio_rd;
    logic [31:0] lcl_mmio_addr;
    logic [31:0] lcl_mmio_din;
    logic        lcl_mmio_ack;
    logic        lcl_mmio_rsp;
    logic [31:0] lcl_mmio_dout;
    logic        lcl_mmio_dv;

    modport master (
        input  req0_wr, req0_rd, req0_addr, req0_din,
        input  req1_wr, req1_rd, req1_addr, req1_din,
        output req0_ack, req0_dv, req0_rsp, req0_dout,
        output req1_ack, req1_dv, req1_rsp, req1_dout,
        output lcl_mmio_wr, lcl_mmio_rd, lcl_mmio_addr, lcl_mmio_din,
        input  lcl_mmio_ack, lcl_mmio_rsp, lcl_mmio_dout, lcl_mmio_dv
    );

    modport slave (
        output req0_wr, req0_rd, req0_addr, req0_din,
        output req1_wr, req1_rd, req1_addr, req1_din,
        input  req0_ack, req0_dv, req0_rsp, req0_dout,
        input  req1_ack, req1_dv, req1_rsp, req1_dout,
        input  lcl_mmio_wr, lcl_mmio_rd, lcl_mmio_addr, lcl_mmio_din,
        output lcl_mmio_ack, lcl_mmio_rsp, lcl_mmio_dout, lcl_mmio_dv
    );
endinterface

// File: rtl/lcl_mmio_arbiter.sv
// Two-requester round-robin arbiter for the local MMIO register bus.
// One pending slot per requester, one downstream transaction at a time,
// watchdog with error completion followed by drain of the late response.
module lcl_mmio_arbiter #(
    parameter int unsigned          TIMEOUT_W      = 16,
    parameter logic [TIMEOUT_W-1:0] TIMEOUT_CYCLES = 16'd4096,
    parameter logic [31:0]          ERR_RDATA      = 32'hDEAD_BEEF
) (
    input  logic                clk,
    input  logic                resetn,
    lcl_mmio_arbiter_if.master  bus,
    input  logic                err_clear,
    output logic                timeout_err,
    output logic                proto_err
);

    typedef enum logic [1:0] {StIdle, StIssue, StWait, StDrain} state_e;

    state_e                 state_q, state_d;
    logic                   rr_q, rr_d;          // requester favoured on a tie
    logic                   owner_q, owner_d;
    logic                   cur_rd_q, cur_rd_d;
    logic [1:0]             pend_q, pend_d;
    logic [1:0]             pend_rd_q, pend_rd_d;
    logic [1:0][31:0]       pend_addr_q, pend_addr_d;
    logic [1:0][31:0]       pend_din_q, pend_din_d;
    logic [TIMEOUT_W-1:0]   wdog_q, wdog_d;
    logic                   mmio_wr_q, mmio_wr_d;
    logic                   mmio_rd_q, mmio_rd_d;
    logic [31:0]            mmio_addr_q, mmio_addr_d;
    logic [31:0]            mmio_din_q, mmio_din_d;
    logic [1:0]             ack_q, ack_d;
    logic [1:0]             dv_q, dv_d;
    logic [1:0]             rsp_q, rsp_d;
    logic [1:0][31:0]       dout_q, dout_d;
    logic                   timeout_err_q, timeout_err_d;
    logic                   proto_err_q, proto_err_d;

    logic [1:0]             strb_wr, strb_rd, busy;
    logic [1:0][31:0]       strb_addr, strb_din;
    logic                   in_flight, gnt, proto_set, tmo_set;
    logic                   rsp_match, rsp_wrong;

    assign strb_wr   = {bus.req1_wr, bus.req0_wr};
    assign strb_rd   = {bus.req1_rd, bus.req0_rd};
    assign strb_addr = {bus.req1_addr, bus.req0_addr};
    assign strb_din  = {bus.req1_din, bus.req0_din};

    // The owner counts as busy until its response has been issued.
    assign in_flight = (state_q == StIssue) || (state_q == StWait);
    assign busy[0]   = pend_q[0] | (in_flight & ~owner_q);
    assign busy[1]   = pend_q[1] | (in_flight & owner_q);

    // Response of the type matching the current transaction, and of the other type.
    assign rsp_match = cur_rd_q ? bus.lcl_mmio_dv : bus.lcl_mmio_ack;
    assign rsp_wrong = cur_rd_q ? bus.lcl_mmio_ack : bus.lcl_mmio_dv;

    // Next-state: request capture, arbitration FSM, watchdog and sticky flags.
    always_comb begin
        state_d     = state_q;
        rr_d        = rr_q;
        owner_d     = owner_q;
        cur_rd_d    = cur_rd_q;
        pend_d      = pend_q;
        pend_rd_d   = pend_rd_q;
        pend_addr_d = pend_addr_q;
        pend_din_d  = pend_din_q;
        wdog_d      = wdog_q;
        mmio_wr_d   = 1'b0;
        mmio_rd_d   = 1'b0;
        mmio_addr_d = mmio_addr_q;
        mmio_din_d  = mmio_din_q;
        ack_d       = '0;
        dv_d        = '0;
        rsp_d       = '0;
        dout_d      = '0;
        gnt         = 1'b0;
        proto_set   = 1'b0;
        tmo_set     = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (bus.lcl_mmio_ack || bus.lcl_mmio_dv) begin
                    proto_set = 1'b1;
                end
                if (pend_q != 2'b00) begin
                    gnt         = (pend_q == 2'b11) ? rr_q : pend_q[1];
                    owner_d     = gnt;
                    cur_rd_d    = pend_rd_q[gnt];
                    mmio_wr_d   = ~pend_rd_q[gnt];
                    mmio_rd_d   = pend_rd_q[gnt];
                    mmio_addr_d = pend_addr_q[gnt];
                    mmio_din_d  = pend_din_q[gnt];
                    state_d     = StIssue;
                end
            end
            StIssue: begin
                if (bus.lcl_mmio_ack || bus.lcl_mmio_dv) begin
                    proto_set = 1'b1;
                end
                pend_d[owner_q] = 1'b0;
                rr_d            = ~owner_q;
                wdog_d          = '0;
                state_d         = StWait;
            end
            StWait: begin
                if (rsp_wrong) begin
                    proto_set = 1'b1;
                end
                if (rsp_match) begin
                    ack_d[owner_q]  = ~cur_rd_q;
                    dv_d[owner_q]   = cur_rd_q;
                    rsp_d[owner_q]  = bus.lcl_mmio_rsp;
                    dout_d[owner_q] = cur_rd_q ? bus.lcl_mmio_dout : 32'h0;
                    state_d         = StIdle;
                end else begin
                    wdog_d = wdog_q + TIMEOUT_W'(1);
                    // A zero limit never matches before wrap, so it is gated explicitly.
                    if ((TIMEOUT_CYCLES != '0) && (wdog_d == TIMEOUT_CYCLES)) begin
                        ack_d[owner_q]  = ~cur_rd_q;
                        dv_d[owner_q]   = cur_rd_q;
                        rsp_d[owner_q]  = 1'b1;
                        dout_d[owner_q] = cur_rd_q ? ERR_RDATA : 32'h0;
                        tmo_set         = 1'b1;
                        state_d         = StDrain;
                    end
                end
            end
            StDrain: begin
                if (rsp_wrong) begin
                    proto_set = 1'b1;
                end
                if (rsp_match) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        // Capture new strobes; illegal or colliding strobes are dropped.
        for (int n = 0; n < 2; n++) begin
            if (strb_wr[n] || strb_rd[n]) begin
                if ((strb_wr[n] && strb_rd[n]) || busy[n]) begin
                    proto_set = 1'b1;
                end else begin
                    pend_d[n]      = 1'b1;
                    pend_rd_d[n]   = strb_rd[n];
                    pend_addr_d[n] = strb_addr[n];
                    pend_din_d[n]  = strb_din[n];
                end
            end
        end

        // Set wins over clear.
        timeout_err_d = tmo_set | (timeout_err_q & ~err_clear);
        proto_err_d   = proto_set | (proto_err_q & ~err_clear);
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q       <= StIdle;
            rr_q          <= 1'b0;
            owner_q       <= 1'b0;
            cur_rd_q      <= 1'b0;
            pend_q        <= '0;
            pend_rd_q     <= '0;
            pend_addr_q   <= '0;
            pend_din_q    <= '0;
            wdog_q        <= '0;
            mmio_wr_q     <= 1'b0;
            mmio_rd_q     <= 1'b0;
            mmio_addr_q   <= '0;
            mmio_din_q    <= '0;
            ack_q         <= '0;
            dv_q          <= '0;
            rsp_q         <= '0;
            dout_q        <= '0;
            timeout_err_q <= 1'b0;
            proto_err_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            rr_q          <= rr_d;
            owner_q       <= owner_d;
            cur_rd_q      <= cur_rd_d;
            pend_q        <= pend_d;
            pend_rd_q     <= pend_rd_d;
            pend_addr_q   <= pend_addr_d;
            pend_din_q    <= pend_din_d;
            wdog_q        <= wdog_d;
            mmio_wr_q     <= mmio_wr_d;
            mmio_rd_q     <= mmio_rd_d;
            mmio_addr_q   <= mmio_addr_d;
            mmio_din_q    <= mmio_din_d;
            ack_q         <= ack_d;
            dv_q          <= dv_d;
            rsp_q         <= rsp_d;
            dout_q        <= dout_d;
            timeout_err_q <= timeout_err_d;
            proto_err_q   <= proto_err_d;
        end
    end

    assign bus.lcl_mmio_wr   = mmio_wr_q;
    assign bus.lcl_mmio_rd   = mmio_rd_q;
    assign bus.lcl_mmio_addr = mmio_addr_q;
    assign bus.lcl_mmio_din  = mmio_din_q;
    assign bus.req0_ack      = ack_q[0];
    assign bus.req0_dv       = dv_q[0];
    assign bus.req0_rsp      = rsp_q[0];
    assign bus.req0_dout     = dout_q[0];
    assign bus.req1_ack      = ack_q[1];
    assign bus.req1_dv       = dv_q[1];
    assign bus.req1_rsp      = rsp_q[1];
    assign bus.req1_dout     = dout_q[1];
    assign timeout_err       = timeout_err_q;
    assign proto_err         = proto_err_q;

endmodule
